// File: rtl/snn_pkg.sv
// -----------------------------------------------------------------------------
// snn_pkg
// Shared definitions for the SNN frame controller: controller state encoding,
// result-encoding constant, default frame geometry and the result byte encoder.
// No ports (package).
// -----------------------------------------------------------------------------
package snn_pkg;

  // Frame controller states
  typedef enum logic [2:0] {
    ST_LOAD    = 3'd0,
    ST_UNPACK  = 3'd1,
    ST_CALC    = 3'd2,
    ST_SEND    = 3'd3,
    ST_WAIT_TX = 3'd4
  } state_e;

  localparam logic [7:0] ASCII_ZERO     = 8'h30;
  localparam int         DEF_NUM_PIXELS = 784;
  localparam int         DEF_RESULT_W   = 4;

  // Builds the transmitted result byte; the addition wraps modulo 8 bits.
  function automatic logic [7:0] encode_result(input logic ascii, input logic [7:0] res8);
    logic [7:0] byte_v;
    if (ascii) begin
      byte_v = ASCII_ZERO + res8;
    end else begin
      byte_v = res8;
    end
    return byte_v;
  endfunction

endpackage

// File: rtl/snn_byte_unpack.sv
// -----------------------------------------------------------------------------
// snn_byte_unpack
// Holds one received byte and presents it LSB-first, one bit per shift.
// Ports:
//   clk, rst       : clock, asynchronous active-high reset
//   load_i         : capture data_i and restart the bit counter
//   data_i [7:0]   : byte to capture
//   shift_i        : consume the current bit (shift right)
//   bit_o          : current bit (shreg[0])
//   last_bit_o     : the bit being presented is bit 7 of the byte
// -----------------------------------------------------------------------------
module snn_byte_unpack
  import snn_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       load_i,
  input  logic [7:0] data_i,
  input  logic       shift_i,
  output logic       bit_o,
  output logic       last_bit_o
);

  logic [7:0] shreg_q;
  logic [2:0] bit_cnt_q;

  // Shift register and bit counter; load has priority over shift
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shreg_q   <= 8'h00;
      bit_cnt_q <= 3'd0;
    end else if (load_i) begin
      shreg_q   <= data_i;
      bit_cnt_q <= 3'd0;
    end else if (shift_i) begin
      shreg_q   <= {1'b0, shreg_q[7:1]};
      bit_cnt_q <= bit_cnt_q + 3'd1;
    end else begin
      shreg_q   <= shreg_q;
      bit_cnt_q <= bit_cnt_q;
    end
  end

  assign bit_o      = shreg_q[0];
  assign last_bit_o = (bit_cnt_q == 3'd7);

endmodule

// File: rtl/snn_frame_ctrl.sv
// -----------------------------------------------------------------------------
// snn_frame_ctrl
// Collects UART bytes into a 1-bit-wide pixel RAM (LSB first), starts the SNN
// core once a frame is complete, then forwards the classified digit to the
// UART transmitter and the LEDs. Recovers from stalled partial frames via an
// inter-byte timeout and flags bytes arriving while busy (overrun).
// Ports:
//   clk, rst                 : clock, asynchronous active-high reset
//   rx_valid, rx_data        : received byte strobe / data
//   ram_we, ram_addr, ram_wdata : pixel RAM write port (address shared with core)
//   core_addr                : core read address, routed to ram_addr in CALC
//   core_start / core_done   : core handshake pulses
//   core_result              : core result, valid with core_done
//   tx_start, tx_data, tx_done : transmitter handshake
//   led                      : last result, zero-extended
//   frame_err                : pulse when a partial frame is discarded
//   overrun                  : sticky, byte received outside LOAD
// -----------------------------------------------------------------------------
module snn_frame_ctrl
  import snn_pkg::*;
#(
  parameter int NUM_PIXELS  = DEF_NUM_PIXELS,
  parameter int RESULT_W    = DEF_RESULT_W,
  parameter int ASCII_MODE  = 1,
  parameter int TIMEOUT_CYC = 2_000_000,
  parameter int ADDR_W      = (NUM_PIXELS > 1) ? $clog2(NUM_PIXELS) : 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                rx_valid,
  input  logic [7:0]          rx_data,
  output logic                ram_we,
  output logic [ADDR_W-1:0]   ram_addr,
  output logic                ram_wdata,
  input  logic [ADDR_W-1:0]   core_addr,
  output logic                core_start,
  input  logic                core_done,
  input  logic [RESULT_W-1:0] core_result,
  output logic                tx_start,
  output logic [7:0]          tx_data,
  input  logic                tx_done,
  output logic [7:0]          led,
  output logic                frame_err,
  output logic                overrun
);

  localparam int IDLE_W = (TIMEOUT_CYC > 0) ? $clog2(TIMEOUT_CYC + 1) : 1;
  localparam logic [IDLE_W-1:0] IDLE_LIM = IDLE_W'(TIMEOUT_CYC);
  localparam logic [ADDR_W-1:0] LAST_PIX = ADDR_W'(NUM_PIXELS - 1);
  localparam logic              ASCII_EN = (ASCII_MODE != 0);

  state_e                state_q;
  logic [ADDR_W-1:0]     pix_cnt_q;
  logic [IDLE_W-1:0]     idle_cnt_q;
  logic [RESULT_W-1:0]   result_q;
  logic                  core_start_q;
  logic                  tx_start_q;
  logic [7:0]            tx_data_q;
  logic [7:0]            led_q;
  logic                  frame_err_q;
  logic                  overrun_q;

  logic unpack_load_s;
  logic unpack_shift_s;
  logic unpack_bit_s;
  logic unpack_last_s;
  logic timeout_hit_s;
  logic pix_last_s;
  logic [7:0] result8_s;

  assign unpack_load_s  = (state_q == ST_LOAD) && rx_valid;
  assign unpack_shift_s = (state_q == ST_UNPACK);
  assign pix_last_s     = (pix_cnt_q == LAST_PIX);
  assign result8_s      = 8'(core_result);

  // Timeout fires only while a partial frame is pending in LOAD
  assign timeout_hit_s  = (TIMEOUT_CYC != 0) && (state_q == ST_LOAD) &&
                          (pix_cnt_q != ADDR_W'(0)) && (idle_cnt_q == IDLE_LIM);

  snn_byte_unpack u_unpack (
    .clk        (clk),
    .rst        (rst),
    .load_i     (unpack_load_s),
    .data_i     (rx_data),
    .shift_i    (unpack_shift_s),
    .bit_o      (unpack_bit_s),
    .last_bit_o (unpack_last_s)
  );

  // Controller FSM with pixel counter, timeout counter and result path
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_LOAD;
      pix_cnt_q    <= ADDR_W'(0);
      idle_cnt_q   <= IDLE_W'(0);
      result_q     <= RESULT_W'(0);
      core_start_q <= 1'b0;
      tx_start_q   <= 1'b0;
      tx_data_q    <= 8'h00;
      led_q        <= 8'h00;
      frame_err_q  <= 1'b0;
      overrun_q    <= 1'b0;
    end else begin
      core_start_q <= 1'b0;
      tx_start_q   <= 1'b0;
      frame_err_q  <= 1'b0;

      if (rx_valid && (state_q != ST_LOAD)) begin
        overrun_q <= 1'b1;
      end else begin
        overrun_q <= overrun_q;
      end

      case (state_q)
        ST_LOAD: begin
          // A byte arriving on the expiry cycle still starts at address 0
          if (timeout_hit_s) begin
            pix_cnt_q   <= ADDR_W'(0);
            idle_cnt_q  <= IDLE_W'(0);
            frame_err_q <= 1'b1;
          end else if ((pix_cnt_q == ADDR_W'(0)) || rx_valid) begin
            idle_cnt_q  <= IDLE_W'(0);
          end else begin
            idle_cnt_q  <= idle_cnt_q + IDLE_W'(1);
          end
          if (rx_valid) begin
            state_q <= ST_UNPACK;
          end else begin
            state_q <= ST_LOAD;
          end
        end

        ST_UNPACK: begin
          idle_cnt_q <= IDLE_W'(0);
          // Final pixel ends the byte early; leftover bits are dropped
          if (pix_last_s) begin
            pix_cnt_q    <= ADDR_W'(0);
            core_start_q <= 1'b1;
            state_q      <= ST_CALC;
          end else begin
            pix_cnt_q <= pix_cnt_q + ADDR_W'(1);
            if (unpack_last_s) begin
              state_q <= ST_LOAD;
            end else begin
              state_q <= ST_UNPACK;
            end
          end
        end

        ST_CALC: begin
          idle_cnt_q <= IDLE_W'(0);
          if (core_done) begin
            result_q   <= core_result;
            led_q      <= result8_s;
            tx_data_q  <= encode_result(ASCII_EN, result8_s);
            tx_start_q <= 1'b1;
            state_q    <= ST_SEND;
          end else begin
            state_q <= ST_CALC;
          end
        end

        ST_SEND: begin
          idle_cnt_q <= IDLE_W'(0);
          state_q    <= ST_WAIT_TX;
        end

        ST_WAIT_TX: begin
          idle_cnt_q <= IDLE_W'(0);
          if (tx_done) begin
            state_q <= ST_LOAD;
          end else begin
            state_q <= ST_WAIT_TX;
          end
        end

        default: begin
          state_q    <= ST_LOAD;
          pix_cnt_q  <= ADDR_W'(0);
          idle_cnt_q <= IDLE_W'(0);
        end
      endcase
    end
  end

  // RAM port: pixel writes during UNPACK, core-owned address during CALC
  always_comb begin
    ram_we    = 1'b0;
    ram_wdata = 1'b0;
    ram_addr  = pix_cnt_q;
    if (state_q == ST_UNPACK) begin
      ram_we    = 1'b1;
      ram_wdata = unpack_bit_s;
    end else if (state_q == ST_CALC) begin
      ram_addr  = core_addr;
    end else begin
      ram_addr  = pix_cnt_q;
    end
  end

  assign core_start = core_start_q;
  assign tx_start   = tx_start_q;
  assign tx_data    = tx_data_q;
  assign led        = led_q;
  assign frame_err  = frame_err_q;
  assign overrun    = overrun_q;

endmodule

// File: tb/tb_snn_frame_ctrl.sv
// -----------------------------------------------------------------------------
// tb_snn_frame_ctrl
// Two DUT copies (ASCII and binary result encoding) share all stimulus.
// Expected pixel writes, core starts and result bytes are queued by a
// frame-level model as bytes are issued; a negedge monitor pops and compares.
// -----------------------------------------------------------------------------
module tb_snn_frame_ctrl;
  localparam int NP = 12;
  localparam int RW = 4;
  localparam int TO = 50;
  localparam int AW = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          rx_valid;
  logic [7:0]    rx_data;
  logic [AW-1:0] core_addr;
  logic          core_done;
  logic [RW-1:0] core_result;
  logic          tx_done;

  logic          ram_we_a, ram_wdata_a, core_start_a, tx_start_a, frame_err_a, overrun_a;
  logic [AW-1:0] ram_addr_a;
  logic [7:0]    tx_data_a, led_a;
  logic          ram_we_b, ram_wdata_b, core_start_b, tx_start_b, frame_err_b, overrun_b;
  logic [AW-1:0] ram_addr_b;
  logic [7:0]    tx_data_b, led_b;

  always #5 clk = ~clk;

  snn_frame_ctrl #(.NUM_PIXELS(NP), .RESULT_W(RW), .ASCII_MODE(1), .TIMEOUT_CYC(TO)) u_asc (
    .clk(clk), .rst(rst), .rx_valid(rx_valid), .rx_data(rx_data),
    .ram_we(ram_we_a), .ram_addr(ram_addr_a), .ram_wdata(ram_wdata_a),
    .core_addr(core_addr), .core_start(core_start_a), .core_done(core_done),
    .core_result(core_result), .tx_start(tx_start_a), .tx_data(tx_data_a),
    .tx_done(tx_done), .led(led_a), .frame_err(frame_err_a), .overrun(overrun_a)
  );

  snn_frame_ctrl #(.NUM_PIXELS(NP), .RESULT_W(RW), .ASCII_MODE(0), .TIMEOUT_CYC(TO)) u_bin (
    .clk(clk), .rst(rst), .rx_valid(rx_valid), .rx_data(rx_data),
    .ram_we(ram_we_b), .ram_addr(ram_addr_b), .ram_wdata(ram_wdata_b),
    .core_addr(core_addr), .core_start(core_start_b), .core_done(core_done),
    .core_result(core_result), .tx_start(tx_start_b), .tx_data(tx_data_b),
    .tx_done(tx_done), .led(led_b), .frame_err(frame_err_b), .overrun(overrun_b)
  );

  typedef struct { int addr; int data; } wr_t;

  int  checks = 0;
  int  errors = 0;
  wr_t wr_q[$];
  int  tx_asc_q[$];
  int  tx_bin_q[$];
  int  start_pend = 0;
  int  ferr_seen = 0;
  int  ferr_exp = 0;
  int  mdl_pix = 0;
  int  mdl_ovr = 0;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Monitor: every observed output event must match the head of its queue
  always @(negedge clk) begin : monitor
    wr_t w;
    if (!rst) begin
      if (ram_we_a) begin
        if (wr_q.size() == 0) begin
          check("unexpected_write", 1, 0);
        end else begin
          w = wr_q.pop_front();
          check("wr_addr", int'(ram_addr_a), w.addr);
          check("wr_data", int'(ram_wdata_a), w.data);
        end
      end
      if (core_start_a) begin
        check("core_start_expected", int'(start_pend > 0), 1);
        if (start_pend > 0) start_pend--;
      end
      if (tx_start_a) begin
        if (tx_asc_q.size() == 0) begin
          check("unexpected_tx", 1, 0);
        end else begin
          check("tx_ascii", int'(tx_data_a), tx_asc_q.pop_front());
          check("tx_binary", int'(tx_data_b), tx_bin_q.pop_front());
        end
      end
      if (frame_err_a) ferr_seen++;
    end
  end

  // Model: a byte fills the next pixels LSB-first until the frame is full
  task automatic send_byte(input logic [7:0] b, output bit done);
    int nw;
    wr_t w;
    nw = 0;
    done = 1'b0;
    for (int i = 0; i < 8; i++) begin
      w.addr = mdl_pix;
      w.data = int'(b[i]);
      wr_q.push_back(w);
      nw++;
      mdl_pix++;
      if (mdl_pix == NP) begin
        mdl_pix = 0;
        done = 1'b1;
        start_pend++;
        break;
      end
    end
    rx_data  = b;
    rx_valid = 1'b1;
    tick();
    rx_valid = 1'b0;
    repeat (nw) tick();
  endtask

  task automatic send_frame(input int max_gap);
    bit done;
    done = 1'b0;
    while (!done) begin
      send_byte(8'($urandom), done);
      if (!done && max_gap > 0) repeat ($urandom_range(0, max_gap)) tick();
    end
  endtask

  // Called in the first CALC cycle
  task automatic result_phase(input logic [RW-1:0] r, input bit do_ovr);
    logic [7:0] asc;
    core_addr = AW'($urandom);
    #1;
    check("calc_ram_addr", int'(ram_addr_a), int'(core_addr));
    check("calc_ram_we", int'(ram_we_a), 0);
    if (do_ovr) begin
      rx_data  = 8'($urandom);
      rx_valid = 1'b1;
      tick();
      rx_valid = 1'b0;
      mdl_ovr  = 1;
      check("overrun_set", int'(overrun_a), 1);
    end
    repeat ($urandom_range(0, 3)) tick();
    asc = 8'h30 + {4'h0, r};
    tx_asc_q.push_back(int'(asc));
    tx_bin_q.push_back(int'(r));
    core_result = r;
    core_done   = 1'b1;
    tick();
    core_done   = 1'b0;
    core_result = RW'($urandom);
    check("led", int'(led_a), int'(r));
    tick();
    repeat ($urandom_range(0, 3)) tick();
    check("tx_hold", int'(tx_data_a), int'(asc));
    tx_done = 1'b1;
    tick();
    tx_done = 1'b0;
  endtask

  initial begin
    bit done;
    rst = 1'b1; rx_valid = 1'b0; rx_data = 8'h00; core_addr = '0;
    core_done = 1'b0; core_result = '0; tx_done = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_ram_we", int'(ram_we_a), 0);
    check("rst_ram_addr", int'(ram_addr_a), 0);
    check("rst_ram_wdata", int'(ram_wdata_a), 0);
    check("rst_core_start", int'(core_start_a), 0);
    check("rst_tx_start", int'(tx_start_a), 0);
    check("rst_tx_data", int'(tx_data_a), 0);
    check("rst_tx_data_bin", int'(tx_data_b), 0);
    check("rst_led", int'(led_a), 0);
    check("rst_frame_err", int'(frame_err_a), 0);
    check("rst_overrun", int'(overrun_a), 0);
    rst = 1'b0;
    tick();

    // Directed: 0xA5 then 0xFF completes a 12-pixel frame, result 7
    send_byte(8'hA5, done);
    check("no_start_after_partial", int'(done), 0);
    send_byte(8'hFF, done);
    result_phase(4'd7, 1'b1);

    // Result 9 (binary copy gives 8'h09)
    send_frame(0);
    result_phase(4'd9, 1'b0);

    // Randomized frames with sub-timeout gaps
    for (int f = 0; f < 6; f++) begin
      send_frame(30);
      result_phase(RW'($urandom), bit'($urandom_range(0, 1)));
    end

    // Timeout: partial frame discarded, next frame restarts at address 0
    send_byte(8'($urandom), done);
    repeat (TO + 5) tick();
    mdl_pix = 0;
    ferr_exp++;
    check("frame_err_count_timeout", ferr_seen, ferr_exp);
    send_frame(10);
    result_phase(RW'($urandom), 1'b0);

    // Byte arriving on the expiry cycle: written from address 0
    send_byte(8'($urandom), done);
    repeat (TO) tick();
    mdl_pix = 0;
    ferr_exp++;
    send_byte(8'($urandom), done);
    check("frame_err_count_coincide", ferr_seen, ferr_exp);
    send_byte(8'($urandom), done);
    check("start_after_coincide", int'(done), 1);
    result_phase(RW'($urandom), 1'b0);

    // Reset during UNPACK: only bit 0 gets written before reset
    begin
      wr_t w;
      rx_data = 8'($urandom);
      w.addr = 0;
      w.data = int'(rx_data[0]);
      wr_q.push_back(w);
      rx_valid = 1'b1;
      tick();
      rx_valid = 1'b0;
      tick();
      rst = 1'b1;
      #1;
      check("mid_rst_ram_we", int'(ram_we_a), 0);
      check("mid_rst_core_start", int'(core_start_a), 0);
      check("mid_rst_overrun", int'(overrun_a), 0);
      check("mid_rst_led", int'(led_a), 0);
      check("mid_rst_tx_data", int'(tx_data_a), 0);
      check("mid_rst_queue", wr_q.size(), 0);
      mdl_pix = 0;
      mdl_ovr = 0;
      repeat (2) tick();
      rst = 1'b0;
      tick();
    end
    send_frame(5);
    result_phase(RW'($urandom), 1'b1);

    repeat (5) tick();
    check("final_write_queue", wr_q.size(), 0);
    check("final_tx_queue", tx_asc_q.size(), 0);
    check("final_start_pending", start_pend, 0);
    check("final_frame_err", ferr_seen, ferr_exp);
    check("final_overrun", int'(overrun_a), mdl_ovr);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/snn_frame_ctrl.md
# snn_frame_ctrl

Parametrised frame controller for the SNN top level. It accepts received UART bytes, unpacks them LSB-first into a 1-bit-wide input RAM, and starts the SNN core once a full frame is stored. When the core finishes, it latches the classified digit and hands one result byte to the UART transmitter. It generalises the fixed 784-pixel load/calculate/transmit flow with configurable frame size, ASCII/binary result encoding, inter-byte timeout recovery and overrun detection.

## Interface
- `NUM_PIXELS`, default 784: pixels per frame. Must be ≥ 1.
- `RESULT_W`, default 4: width of the core result.
- `ASCII_MODE`, default 1: selects the result encoding. 1 sends 8'h30 + result; 0 sends the zero-extended result.
- `TIMEOUT_CYC`, default 2_000_000: idle cycles allowed mid-frame before the partial frame is discarded. 0 disables the timeout.
- `ADDR_W`, default $clog2(NUM_PIXELS): RAM address width (derived).

Ports:
- `clk` input 1: system clock. One clock domain.
- `rst` input 1: reset, asynchronous, active-high.
- `rx_valid` input 1: one-cycle pulse when `rx_data` holds a received byte.
- `rx_data` input 8: received byte.
- `ram_we` output 1: input RAM write enable.
- `ram_addr` output ADDR_W: input RAM address.
- `ram_wdata` output 1: pixel bit to write.
- `core_addr` input ADDR_W: address requested by the core during calculation.
- `core_start` output 1: one-cycle pulse that starts the core.
- `core_done` input 1: one-cycle pulse when the core has finished.
- `core_result` input RESULT_W: core result, valid while `core_done` is high.
- `tx_start` output 1: one-cycle pulse that starts transmitter output.
- `tx_data` output 8: result byte for the transmitter.
- `tx_done` input 1: one-cycle pulse when transmission completes.
- `led` output 8: last result, zero-extended.
- `frame_err` output 1: one-cycle pulse when a partial frame is discarded on timeout.
- `overrun` output 1: sticky flag. Set when a byte arrives outside LOAD. Cleared only by reset.

## Operation
- **LOAD.** On `rx_valid`, latch `rx_data` into the shift register and go to UNPACK. While `pix_cnt != 0`, `idle_cnt` counts cycles. When `idle_cnt` reaches TIMEOUT_CYC:
  - clear `pix_cnt`;
  - pulse `frame_err`.
- **UNPACK.** Each cycle:
  - write `ram_wdata` = shreg[0] to `ram_addr` = `pix_cnt`;
  - shift the register right;
  - increment `pix_cnt`.

  Exit after 8 writes, or earlier after the write to NUM_PIXELS-1. Any bits left in the last byte are discarded.
  - If the last pixel was written, clear `pix_cnt` and go to CALC, pulsing `core_start` in the first CALC cycle.
  - Otherwise return to LOAD.
- **CALC.** `ram_addr` = `core_addr` and `ram_we` = 0. On `core_done`:
  - latch `core_result` into `result_q`;
  - update `led`;
  - go to SEND.
- **SEND.** Pulse `tx_start` for one cycle with `tx_data` valid, then go to WAIT_TX.
- **WAIT_TX.** On `tx_done`, go to LOAD. `tx_data` is held stable until `tx_done`.
- **Overrun.** An `rx_valid` pulse in any state other than LOAD drops the byte and sets `overrun`.
- **Arithmetic.** `tx_data` is computed modulo 8 bits. `pix_cnt` never wraps; it is cleared explicitly.

## Timing
- **Reset values:** every output is 0, the state is LOAD, and all counters are 0.
- **Write latency:** for a byte accepted in cycle N, `ram_we` is high in cycles N+1..N+8, with bit i written in cycle N+1+i. The block returns to LOAD in cycle N+9.
- **Start latency:** `core_start` is high exactly one cycle, immediately after the final pixel write.
- **Result to transmit:** `core_done` in cycle M gives `led`/`result_q` updated in M+1 and `tx_start` high in M+1.
- **Timeout coincidence:** if `rx_valid` arrives in the same cycle the timeout expires, the timeout wins the counter. `pix_cnt` is cleared and the byte is written starting at address 0. `frame_err` still pulses.
- **Timeout counter reset:** `idle_cnt` is cleared on every accepted byte and whenever `pix_cnt` is 0.
- **Reset mid-operation:** any state returns to LOAD immediately. `ram_we` and `core_start` drop asynchronously and the partial frame is lost.

## Structure
- **Package `snn_pkg`:** holds
  - the state enum (LOAD, UNPACK, CALC, SEND, WAIT_TX);
  - `ASCII_ZERO` = 8'h30;
  - the default `NUM_PIXELS` and `RESULT_W` constants.
- **Sub-module `snn_byte_unpack`:** owns the 8-bit shift register, the bit counter and the load/shift/done handshake. The top controller owns the FSM, `pix_cnt`, the timeout and the result path.

## Test plan
- **Basic unpack** (NUM_PIXELS=16): send byte 0xA5 → writes to addresses 0..7 with data 1,0,1,0,0,1,0,1; no `core_start`.
- **Partial last byte** (NUM_PIXELS=12): send 0x00 then 0xFF → second byte writes addresses 8..11 as 1 only; bits 4..7 are never written. `core_start` pulses one cycle after the address-11 write.
- **Result path, ASCII_MODE=1:** `core_done` with result 7 → `led`=8'h07 and `tx_start` with `tx_data`=8'h37 next cycle. `tx_done` → back to LOAD.
- **Result path, ASCII_MODE=0:** result 9 → `tx_data`=8'h09.
- **Timeout** (TIMEOUT_CYC=50): send one byte, then idle 50 cycles → `frame_err` pulses once. The next byte writes from address 0.
- **Overrun and reset:**
  - `rx_valid` during CALC → byte dropped, `overrun`=1, CALC continues.
  - Assert `rst` during UNPACK → all outputs 0 at once, and the next byte starts at address 0.
